// File: rtl/arcade_audio_pkg.sv
// Shared types and constants for the arcade audio mixer: frame FSM states,
// the Q2.2 unity gain and the accumulator sizing rule.
package arcade_audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    COMMIT = 2'd2
  } mix_state_e;

  localparam logic [3:0] GAIN_UNITY = 4'd4;

  // Product width plus enough headroom to sum NUM_CH full-scale products.
  function automatic int acc_width(input int in_w, input int num_ch);
    return in_w + 4 + $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/sd_dac1.sv
// First-order delta-sigma modulator: the carry of a wrapping OUT_W-bit
// phase accumulator is the 1-bit output stream.
module sd_dac1 #(
  parameter int OUT_W = 12
) (
  input  logic             clk_sys,
  input  logic             res_n,
  input  logic [OUT_W-1:0] pcm_i,
  output logic             bit_o
);

  logic [OUT_W:0] acc_q, acc_d;

  // Only the low OUT_W bits feed back, so the carry bit is emitted once per step.
  always_comb begin
    acc_d = {1'b0, acc_q[OUT_W-1:0]} + {1'b0, pcm_i};
  end

  // Phase accumulator register.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bit_o = acc_q[OUT_W];

endmodule

// File: rtl/arcade_audio_mixer.sv
// Arcade audio mixer: one time-shared multiply-accumulate across NUM_CH
// snapshotted channels per frame, saturating PCM commit, delta-sigma outputs.
module arcade_audio_mixer
  import arcade_audio_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 12
) (
  input  logic                   clk_sys,
  input  logic                   res_n,
  input  logic                   sample_tick,
  input  logic [NUM_CH*IN_W-1:0] ch_data,
  input  logic [NUM_CH*4-1:0]    ch_gain,
  input  logic [NUM_CH*2-1:0]    ch_pan,
  input  logic                   mute,
  input  logic                   clr_ovr,
  output logic [OUT_W-1:0]       pcm_l,
  output logic [OUT_W-1:0]       pcm_r,
  output logic                   pcm_valid,
  output logic                   audio_l,
  output logic                   audio_r,
  output logic                   busy,
  output logic                   overrun,
  output logic                   clip_l,
  output logic                   clip_r
);

  localparam int ACC_W     = acc_width(IN_W, NUM_CH);
  localparam int PROD_W    = IN_W + 4;
  localparam int CNT_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GAIN_FRAC = $clog2(GAIN_UNITY);
  localparam int CMP_W     = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);
  localparam logic [CMP_W-1:0] PCM_MAX = {{(CMP_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  mix_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  snap_data_q [NUM_CH];
  logic [IN_W-1:0]  snap_data_d [NUM_CH];
  logic [3:0]       snap_gain_q [NUM_CH];
  logic [3:0]       snap_gain_d [NUM_CH];
  logic [1:0]       snap_pan_q  [NUM_CH];
  logic [1:0]       snap_pan_d  [NUM_CH];
  logic [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [OUT_W-1:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic             pcm_valid_q, pcm_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             clip_l_q, clip_l_d, clip_r_q, clip_r_d;

  logic [PROD_W-1:0] prod_s;
  logic [1:0]        sel_pan_s;
  logic [CMP_W-1:0]  lvl_l_s, lvl_r_s;
  logic [OUT_W-1:0]  res_l_s, res_r_s;
  logic              sat_l_s, sat_r_s;

  // The single multiplier, steered by the channel counter.
  always_comb begin
    prod_s    = PROD_W'(snap_data_q[cnt_q]) * PROD_W'(snap_gain_q[cnt_q]);
    sel_pan_s = snap_pan_q[cnt_q];
  end

  // Drop the Q2.2 fraction, then clamp; mute wins over saturation.
  always_comb begin
    lvl_l_s = CMP_W'(acc_l_q >> GAIN_FRAC);
    lvl_r_s = CMP_W'(acc_r_q >> GAIN_FRAC);
    sat_l_s = (lvl_l_s > PCM_MAX);
    sat_r_s = (lvl_r_s > PCM_MAX);
    if (mute) begin
      res_l_s = '0;
      res_r_s = '0;
    end else begin
      res_l_s = sat_l_s ? PCM_MAX[OUT_W-1:0] : lvl_l_s[OUT_W-1:0];
      res_r_s = sat_r_s ? PCM_MAX[OUT_W-1:0] : lvl_r_s[OUT_W-1:0];
    end
  end

  // Frame FSM next state, snapshot capture, accumulation and flag updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    snap_data_d = snap_data_q;
    snap_gain_d = snap_gain_q;
    snap_pan_d  = snap_pan_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    pcm_l_d     = pcm_l_q;
    pcm_r_d     = pcm_r_q;
    pcm_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          for (int i = 0; i < NUM_CH; i++) begin
            snap_data_d[i] = ch_data[i*IN_W +: IN_W];
            snap_gain_d[i] = ch_gain[i*4 +: 4];
            snap_pan_d[i]  = ch_pan[i*2 +: 2];
          end
          acc_l_d = '0;
          acc_r_d = '0;
          cnt_d   = '0;
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (sel_pan_s[0]) begin
          acc_l_d = acc_l_q + ACC_W'(prod_s);
        end else begin
          acc_l_d = acc_l_q;
        end
        if (sel_pan_s[1]) begin
          acc_r_d = acc_r_q + ACC_W'(prod_s);
        end else begin
          acc_r_d = acc_r_q;
        end
        if (cnt_q == LAST_CH) begin
          cnt_d   = '0;
          state_d = COMMIT;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ACC;
        end
      end
      COMMIT: begin
        pcm_l_d     = res_l_s;
        pcm_r_d     = res_r_s;
        pcm_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d    = (state_d != IDLE);
    // A tick outside IDLE (including the COMMIT exit cycle) is dropped; setting beats clearing.
    overrun_d = (sample_tick && (state_q != IDLE)) ? 1'b1 : (clr_ovr ? 1'b0 : overrun_q);
    clip_l_d  = ((state_q == COMMIT) && sat_l_s && !mute) ? 1'b1 : (clr_ovr ? 1'b0 : clip_l_q);
    clip_r_d  = ((state_q == COMMIT) && sat_r_s && !mute) ? 1'b1 : (clr_ovr ? 1'b0 : clip_r_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_data_q[i] <= '0;
        snap_gain_q[i] <= '0;
        snap_pan_q[i]  <= '0;
      end
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      pcm_l_q     <= '0;
      pcm_r_q     <= '0;
      pcm_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      clip_l_q    <= 1'b0;
      clip_r_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      snap_data_q <= snap_data_d;
      snap_gain_q <= snap_gain_d;
      snap_pan_q  <= snap_pan_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      pcm_l_q     <= pcm_l_d;
      pcm_r_q     <= pcm_r_d;
      pcm_valid_q <= pcm_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      clip_l_q    <= clip_l_d;
      clip_r_q    <= clip_r_d;
    end
  end

  sd_dac1 #(.OUT_W(OUT_W)) u_sd_l (
    .clk_sys (clk_sys),
    .res_n   (res_n),
    .pcm_i   (pcm_l_q),
    .bit_o   (audio_l)
  );

  sd_dac1 #(.OUT_W(OUT_W)) u_sd_r (
    .clk_sys (clk_sys),
    .res_n   (res_n),
    .pcm_i   (pcm_r_q),
    .bit_o   (audio_r)
  );

  assign pcm_l     = pcm_l_q;
  assign pcm_r     = pcm_r_q;
  assign pcm_valid = pcm_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign clip_l    = clip_l_q;
  assign clip_r    = clip_r_q;

endmodule

// File: tb/tb_arcade_audio_mixer.sv
// Bench for arcade_audio_mixer: a 12-bit and an 8-bit output instance share
// stimulus; frame results are scoreboarded and checked on pcm_valid.
module tb_arcade_audio_mixer;
  import arcade_audio_pkg::*;

  localparam int NUM_CH = 3;

  logic        clk_sys = 1'b0;
  logic        res_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        mute = 1'b0;
  logic        clr_ovr = 1'b0;
  logic [23:0] ch_data = 24'h0;
  logic [11:0] ch_gain = 12'h0;
  logic [5:0]  ch_pan = 6'h0;

  logic [11:0] m_pcm_l, m_pcm_r;
  logic        m_valid, m_audio_l, m_audio_r, m_busy, m_overrun, m_clip_l, m_clip_r;
  logic [7:0]  s_pcm_l, s_pcm_r;
  logic        s_valid, s_audio_l, s_audio_r, s_busy, s_overrun, s_clip_l, s_clip_r;

  typedef struct {
    logic [23:0] data;
    logic [11:0] gain;
    logic [5:0]  pan;
    logic        mute;
    logic [11:0] l12, r12;
    logic [7:0]  l8, r8;
    logic        c8l, c8r;
  } vec_t;

  typedef struct {
    logic [11:0] l, r;
    logic        cl, cr;
  } exp_t;

  vec_t vecs [8];
  exp_t q_m [$];
  exp_t q_s [$];
  exp_t mon_m, mon_s;
  logic sat_cl = 1'b0;
  logic sat_cr = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   ones_l, ones_r, ones_s;

  always #5 clk_sys = ~clk_sys;

  arcade_audio_mixer #(.NUM_CH(3), .IN_W(8), .OUT_W(12)) u_dut (
    .clk_sys(clk_sys), .res_n(res_n), .sample_tick(sample_tick),
    .ch_data(ch_data), .ch_gain(ch_gain), .ch_pan(ch_pan),
    .mute(mute), .clr_ovr(clr_ovr),
    .pcm_l(m_pcm_l), .pcm_r(m_pcm_r), .pcm_valid(m_valid),
    .audio_l(m_audio_l), .audio_r(m_audio_r), .busy(m_busy),
    .overrun(m_overrun), .clip_l(m_clip_l), .clip_r(m_clip_r)
  );

  arcade_audio_mixer #(.NUM_CH(3), .IN_W(8), .OUT_W(8)) u_sat (
    .clk_sys(clk_sys), .res_n(res_n), .sample_tick(sample_tick),
    .ch_data(ch_data), .ch_gain(ch_gain), .ch_pan(ch_pan),
    .mute(mute), .clr_ovr(clr_ovr),
    .pcm_l(s_pcm_l), .pcm_r(s_pcm_r), .pcm_valid(s_valid),
    .audio_l(s_audio_l), .audio_r(s_audio_r), .busy(s_busy),
    .overrun(s_overrun), .clip_l(s_clip_l), .clip_r(s_clip_r)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic load(input int i);
    ch_data = vecs[i].data;
    ch_gain = vecs[i].gain;
    ch_pan  = vecs[i].pan;
    mute    = vecs[i].mute;
  endtask

  task automatic push(input int i);
    q_m.push_back('{vecs[i].l12, vecs[i].r12, 1'b0, 1'b0});
    sat_cl = sat_cl | vecs[i].c8l;
    sat_cr = sat_cr | vecs[i].c8r;
    q_s.push_back('{{4'h0, vecs[i].l8}, {4'h0, vecs[i].r8}, sat_cl, sat_cr});
  endtask

  task automatic pulse_clr();
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    check("clr_overrun", m_overrun, 1'b0);
    check("clr_sat_clip_l", s_clip_l, 1'b0);
    check("clr_sat_clip_r", s_clip_r, 1'b0);
    sat_cl = 1'b0;
    sat_cr = 1'b0;
  endtask

  // One isolated frame with latency, pulse width and snapshot isolation checks.
  task automatic run_vec(input int i);
    load(i);
    push(i);
    tick();
    check("busy_after_tick", m_busy, 1'b1);
    ch_data = 24'($urandom);
    ch_gain = 12'($urandom);
    ch_pan  = 6'($urandom);
    step(NUM_CH);
    check("valid_not_early", m_valid, 1'b0);
    step(1);
    check("valid_latency", m_valid, 1'b1);
    step(1);
    check("valid_one_cycle", m_valid, 1'b0);
    check("busy_after_frame", m_busy, 1'b0);
    check("scoreboard_drained", q_m.size() + q_s.size(), 0);
    mute = 1'b0;
  endtask

  // Scoreboard: every pcm_valid pops and compares the oldest expected frame.
  always @(negedge clk_sys) begin
    if (res_n && m_valid) begin
      if (q_m.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL main_unexpected_valid: got pcm_l=0x%0h, expected no frame", m_pcm_l);
      end else begin
        mon_m = q_m.pop_front();
        check("main_pcm_l", m_pcm_l, mon_m.l);
        check("main_pcm_r", m_pcm_r, mon_m.r);
        check("main_clip_l", m_clip_l, mon_m.cl);
        check("main_clip_r", m_clip_r, mon_m.cr);
      end
    end
    if (res_n && s_valid) begin
      if (q_s.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sat_unexpected_valid: got pcm_l=0x%0h, expected no frame", s_pcm_l);
      end else begin
        mon_s = q_s.pop_front();
        check("sat_pcm_l", s_pcm_l, mon_s.l);
        check("sat_pcm_r", s_pcm_r, mon_s.r);
        check("sat_clip_l", s_clip_l, mon_s.cl);
        check("sat_clip_r", s_clip_r, mon_s.cr);
      end
    end
  end

  initial begin
    //          data        gain     pan         mute  l12     r12     l8     r8     c8l   c8r
    vecs[0] = '{24'h302010, 12'h444, 6'b111111, 1'b0, 12'h060, 12'h060, 8'h60, 8'h60, 1'b0, 1'b0};
    vecs[1] = '{24'h5580FF, 12'h044, 6'b111001, 1'b0, 12'h0FF, 12'h080, 8'hFF, 8'h80, 1'b0, 1'b0};
    vecs[2] = '{24'hFFFFFF, 12'hFFF, 6'b111111, 1'b1, 12'h000, 12'h000, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{24'h070103, 12'h321, 6'b100101, 1'b0, 12'h001, 12'h005, 8'h01, 8'h05, 1'b0, 1'b0};
    vecs[4] = '{24'hABCDEF, 12'h888, 6'b000000, 1'b0, 12'h000, 12'h000, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{24'hFFFFFF, 12'hFFF, 6'b111111, 1'b0, 12'hB34, 12'hB34, 8'hFF, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{24'h000080, 12'h008, 6'b000011, 1'b0, 12'h100, 12'h100, 8'hFF, 8'hFF, 1'b1, 1'b1};
    vecs[7] = '{24'h0187FF, 12'h12F, 6'b010101, 1'b0, 12'h400, 12'h000, 8'hFF, 8'h00, 1'b1, 1'b0};

    step(2);
    check("rst_pcm_l", m_pcm_l, 12'h000);
    check("rst_pcm_r", m_pcm_r, 12'h000);
    check("rst_valid", m_valid, 1'b0);
    check("rst_busy", m_busy, 1'b0);
    check("rst_overrun", m_overrun, 1'b0);
    check("rst_clip", {m_clip_l, m_clip_r, s_clip_l, s_clip_r}, 4'h0);
    check("rst_audio", {m_audio_l, m_audio_r}, 2'b00);
    res_n = 1'b1;
    step(2);

    for (int i = 0; i < 8; i++) begin
      run_vec(i);
      if (i == 5 || i == 6) begin
        pulse_clr();
      end
    end

    // Second tick two cycles into a frame, together with clr_ovr.
    pulse_clr();
    load(3);
    push(3);
    tick();
    step(1);
    ch_data = vecs[0].data;
    ch_gain = vecs[0].gain;
    ch_pan  = vecs[0].pan;
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("overrun_set_beats_clr", m_overrun, 1'b1);
    step(4);
    check("overrun_single_frame", q_m.size() + q_s.size(), 0);
    check("overrun_sticky", m_overrun, 1'b1);
    check("overrun_idle", m_busy, 1'b0);

    // Tick coinciding with the COMMIT to IDLE edge.
    pulse_clr();
    load(1);
    push(1);
    tick();
    step(NUM_CH);
    check("commit_busy", m_busy, 1'b1);
    tick();
    check("commit_valid", m_valid, 1'b1);
    check("commit_tick_overrun", m_overrun, 1'b1);
    check("commit_tick_ignored", m_busy, 1'b0);
    step(2);
    check("commit_drained", q_m.size() + q_s.size(), 0);

    // Back-to-back frames at NUM_CH+2 cycle period.
    pulse_clr();
    load(0);
    push(0);
    tick();
    step(NUM_CH);
    load(3);
    push(3);
    step(1);
    tick();
    check("b2b_started", m_busy, 1'b1);
    check("b2b_no_overrun", m_overrun, 1'b0);
    step(NUM_CH + 1);
    check("b2b_second_valid", m_valid, 1'b1);
    step(1);
    check("b2b_drained", q_m.size() + q_s.size(), 0);
    check("b2b_overrun_clear", m_overrun, 1'b0);

    // Reset during ACC cycle 1, with nonzero PCM, clip and overrun beforehand.
    run_vec(5);
    load(0);
    push(0);
    tick();
    tick();
    #2;
    res_n = 1'b0;
    #1;
    q_m.delete();
    q_s.delete();
    sat_cl = 1'b0;
    sat_cr = 1'b0;
    check("arst_pcm_l", m_pcm_l, 12'h000);
    check("arst_pcm_r", m_pcm_r, 12'h000);
    check("arst_sat_pcm_l", s_pcm_l, 8'h00);
    check("arst_valid", m_valid, 1'b0);
    check("arst_busy", m_busy, 1'b0);
    check("arst_overrun", m_overrun, 1'b0);
    check("arst_sat_clip", {s_clip_l, s_clip_r}, 2'b00);
    check("arst_audio", {m_audio_l, m_audio_r}, 2'b00);
    step(3);
    res_n = 1'b1;
    step(8);
    check("no_frame_after_reset", m_pcm_l, 12'h000);
    check("idle_after_reset", m_busy, 1'b0);
    run_vec(1);

    // Delta-sigma density over one full period of each modulator.
    run_vec(7);
    ones_l = 0;
    ones_r = 0;
    ones_s = 0;
    for (int c = 0; c < 4096; c++) begin
      @(negedge clk_sys);
      ones_l += int'(m_audio_l);
      ones_r += int'(m_audio_r);
      if (c < 256) begin
        ones_s += int'(s_audio_l);
      end
    end
    check("ds_density_l", ones_l, 1024);
    check("ds_density_r", ones_r, 0);
    check("ds_density_sat_l", ones_s, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
